// File: rtl/sram_window_ctrl.sv
// Read controller for one main SRAM plus LRU-managed flash-backed windows.
// Hits read the selected macro; misses refill the oldest window first.
module sram_window_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SUB_NUM    = 4,
    parameter int SUB_DEPTH  = 256,
    parameter int MAIN_LOWER = 0,
    parameter int MAIN_UPPER = 4096
) (
    input  logic                  clk,
    input  logic                  grst,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic                  busy,
    output logic                  rmiss,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  flash_req,
    output logic [ADDR_WIDTH-1:0] flash_addr,
    input  logic                  flash_valid,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [SUB_NUM:0]      ram_sel,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata
);

    localparam int OW = $clog2(SUB_DEPTH);
    localparam int CW = (OW > 0) ? OW : 1;
    localparam int TW = ADDR_WIDTH - OW;
    localparam int AW = $clog2(SUB_NUM);
    localparam int SW = SUB_NUM + 1;
    localparam logic [ADDR_WIDTH-1:0] MLO   = ADDR_WIDTH'(MAIN_LOWER);
    localparam logic [ADDR_WIDTH-1:0] MSPAN = ADDR_WIDTH'(MAIN_UPPER - MAIN_LOWER);
    localparam logic [ADDR_WIDTH-1:0] OMASK = ADDR_WIDTH'(SUB_DEPTH - 1);
    localparam logic [CW-1:0]         CLAST = CW'(SUB_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RD, RESP, FILL} state_t;

    state_t                state, nxt_state;
    logic [TW-1:0]         tag [SUB_NUM];
    logic [TW-1:0]         nxt_tag [SUB_NUM];
    logic [AW-1:0]         age [SUB_NUM];
    logic [AW-1:0]         nxt_age [SUB_NUM];
    logic [SUB_NUM-1:0]    valid, nxt_valid;
    logic [CW-1:0]         cnt, nxt_cnt;
    logic [AW-1:0]         cur, nxt_cur;
    logic                  cur_sub, nxt_cur_sub;
    logic                  fill_done, nxt_done;
    logic [ADDR_WIDTH-1:0] req_addr, nxt_req;
    logic                  nxt_busy, nxt_rmiss, nxt_rvalid, nxt_freq, nxt_we;
    logic [DATA_WIDTH-1:0] nxt_rdata, nxt_wdata;
    logic [ADDR_WIDTH-1:0] nxt_faddr, nxt_addr;
    logic [SUB_NUM:0]      nxt_sel;

    logic [ADDR_WIDTH-1:0] main_off;
    logic                  main_hit, sub_hit, has_inv;
    logic [AW-1:0]         sub_idx, vict;

    function automatic logic [SUB_NUM:0] sub_sel(input logic [AW-1:0] i);
        sub_sel = '0;
        sub_sel[32'(i) + 1] = 1'b1;
    endfunction

    // Wrapping subtraction turns the range test into a single compare
    always_comb begin
        main_off = raddr - MLO;
        main_hit = main_off < MSPAN;
        sub_hit  = 1'b0;
        sub_idx  = '0;
        for (int i = 0; i < SUB_NUM; i++) begin
            if (valid[i] && raddr[ADDR_WIDTH-1:OW] == tag[i]) begin
                sub_hit = 1'b1;
                sub_idx = AW'(i);
            end
        end
        has_inv = 1'b0;
        vict    = '0;
        for (int i = SUB_NUM - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                has_inv = 1'b1;
                vict    = AW'(i);
            end
        end
        if (!has_inv) begin
            for (int i = 0; i < SUB_NUM; i++) begin
                if (age[i] == AW'(SUB_NUM - 1)) vict = AW'(i);
            end
        end
    end

    always_comb begin
        nxt_state   = state;
        nxt_tag     = tag;
        nxt_age     = age;
        nxt_valid   = valid;
        nxt_cnt     = cnt;
        nxt_cur     = cur;
        nxt_cur_sub = cur_sub;
        nxt_done    = fill_done;
        nxt_req     = req_addr;
        nxt_busy    = busy;
        nxt_rmiss   = rmiss;
        nxt_rvalid  = 1'b0;
        nxt_rdata   = rdata;
        nxt_freq    = flash_req;
        nxt_faddr   = flash_addr;
        nxt_sel     = '0;
        nxt_we      = 1'b0;
        nxt_addr    = ram_addr;
        nxt_wdata   = ram_wdata;
        unique case (state)
            IDLE: begin
                if (re) begin
                    nxt_req  = raddr;
                    nxt_busy = 1'b1;
                    if (main_hit) begin
                        nxt_state   = RD;
                        nxt_sel     = SW'(1);
                        nxt_addr    = main_off;
                        nxt_cur_sub = 1'b0;
                    end else if (sub_hit) begin
                        nxt_state   = RD;
                        nxt_sel     = sub_sel(sub_idx);
                        nxt_addr    = raddr & OMASK;
                        nxt_cur     = sub_idx;
                        nxt_cur_sub = 1'b1;
                    end else begin
                        nxt_state       = FILL;
                        nxt_cur         = vict;
                        nxt_cur_sub     = 1'b1;
                        nxt_valid[vict] = 1'b0;
                        nxt_cnt         = '0;
                        nxt_done        = 1'b0;
                        nxt_freq        = 1'b1;
                        nxt_rmiss       = 1'b1;
                        nxt_faddr       = raddr & ~OMASK;
                    end
                end
            end
            FILL: begin
                // Last write occupies the bus one cycle before the read
                if (fill_done) begin
                    nxt_state = RD;
                    nxt_sel   = sub_sel(cur);
                    nxt_addr  = req_addr & OMASK;
                end else if (flash_valid) begin
                    nxt_sel   = sub_sel(cur);
                    nxt_we    = 1'b1;
                    nxt_addr  = ADDR_WIDTH'(cnt);
                    nxt_wdata = wdata;
                    nxt_cnt   = cnt + 1'b1;
                    if (cnt == CLAST) begin
                        nxt_tag[cur]   = req_addr[ADDR_WIDTH-1:OW];
                        nxt_valid[cur] = 1'b1;
                        nxt_freq       = 1'b0;
                        nxt_rmiss      = 1'b0;
                        nxt_done       = 1'b1;
                    end
                end
            end
            RD: begin
                nxt_state = RESP;
                if (cur_sub) begin
                    for (int j = 0; j < SUB_NUM; j++) begin
                        if (AW'(j) == cur) nxt_age[j] = '0;
                        else if (age[j] < age[cur]) nxt_age[j] = age[j] + 1'b1;
                    end
                end
            end
            RESP: begin
                nxt_state  = IDLE;
                nxt_rdata  = ram_rdata;
                nxt_rvalid = 1'b1;
                nxt_busy   = 1'b0;
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge grst) begin
        if (!grst) begin
            state      <= IDLE;
            valid      <= '0;
            cnt        <= '0;
            cur        <= '0;
            cur_sub    <= 1'b0;
            fill_done  <= 1'b0;
            req_addr   <= '0;
            busy       <= 1'b0;
            rmiss      <= 1'b0;
            rvalid     <= 1'b0;
            rdata      <= '0;
            flash_req  <= 1'b0;
            flash_addr <= '0;
            ram_sel    <= '0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            for (int i = 0; i < SUB_NUM; i++) begin
                tag[i] <= '0;
                age[i] <= AW'(i);
            end
        end else begin
            state      <= nxt_state;
            tag        <= nxt_tag;
            age        <= nxt_age;
            valid      <= nxt_valid;
            cnt        <= nxt_cnt;
            cur        <= nxt_cur;
            cur_sub    <= nxt_cur_sub;
            fill_done  <= nxt_done;
            req_addr   <= nxt_req;
            busy       <= nxt_busy;
            rmiss      <= nxt_rmiss;
            rvalid     <= nxt_rvalid;
            rdata      <= nxt_rdata;
            flash_req  <= nxt_freq;
            flash_addr <= nxt_faddr;
            ram_sel    <= nxt_sel;
            ram_we     <= nxt_we;
            ram_addr   <= nxt_addr;
            ram_wdata  <= nxt_wdata;
        end
    end

endmodule

// File: tb/tb_sram_window_ctrl.sv
// Directed bench for sram_window_ctrl: SRAM and flash models plus a
// transaction-level window/LRU reference checked every cycle.
module tb_sram_window_ctrl;

    logic        clk = 1'b0;
    logic        grst = 1'b0;
    logic        re = 1'b0;
    logic [31:0] raddr = '0;
    logic        busy, rmiss, rvalid, flash_req, ram_we;
    logic [31:0] rdata, flash_addr, ram_addr, ram_wdata;
    logic        flash_valid = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] ram_rdata = '0;
    logic [4:0]  ram_sel;

    always #5 clk = ~clk;

    sram_window_ctrl #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .SUB_NUM(4), .SUB_DEPTH(4),
        .MAIN_LOWER(0), .MAIN_UPPER(256)
    ) dut (
        .clk(clk), .grst(grst), .re(re), .raddr(raddr),
        .busy(busy), .rmiss(rmiss), .rvalid(rvalid), .rdata(rdata),
        .flash_req(flash_req), .flash_addr(flash_addr),
        .flash_valid(flash_valid), .wdata(wdata),
        .ram_rdata(ram_rdata), .ram_sel(ram_sel), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] flash_word(input logic [31:0] a);
        if (a >= 32'h1004 && a <= 32'h1007) return (a - 32'h1003) * 32'h11;
        return a ^ 32'h5A00_0000;
    endfunction

    // SRAM macros: registered read, one-cycle latency
    logic [31:0] main_mem [256];
    logic [31:0] sub_mem [4][4];

    always @(posedge clk) begin
        if (ram_we) begin
            for (int k = 1; k <= 4; k++)
                if (ram_sel[k]) sub_mem[k-1][ram_addr[1:0]] <= ram_wdata;
        end else if (ram_sel[0]) begin
            ram_rdata <= main_mem[ram_addr[7:0]];
        end else begin
            for (int k = 1; k <= 4; k++)
                if (ram_sel[k]) ram_rdata <= sub_mem[k-1][ram_addr[1:0]];
        end
    end

    // Flash: one word every other cycle while flash_req is high
    int fidx = 0;
    int words_sampled = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!grst || !flash_req) begin
                flash_valid = 1'b0;
                fidx = 0;
            end else if (flash_valid) begin
                flash_valid = 1'b0;
                fidx++;
                words_sampled++;
            end else begin
                flash_valid = 1'b1;
                wdata = flash_word(flash_addr + fidx);
            end
        end
    end

    // Reference: slots hold window bases, lru queue front is most recent
    int          kind;
    bit          txn_open, filling, saw_miss, saw_flash;
    logic [31:0] exp_data, exp_laddr, cur_base, last_rdata, last_read_addr;
    logic [4:0]  exp_sel, last_fill_sel, last_read_sel;
    int          widx, acc_cyc, last_word_cyc, rv_count;
    int          rv_cyc_q[$];
    bit          slot_valid[4];
    logic [31:0] slot_base[4];
    int          lru[$];

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) slot_valid[i] = 1'b0;
        lru = {0, 1, 2, 3};
        txn_open = 1'b0;
        filling = 1'b0;
        widx = 0;
    endfunction

    function automatic void touch(input int s);
        for (int i = 0; i < lru.size(); i++)
            if (lru[i] == s) begin
                lru.delete(i);
                break;
            end
        lru.push_front(s);
    endfunction

    function automatic void model_accept(input logic [31:0] a);
        int slot;
        logic [31:0] base;
        txn_open = 1'b1;
        acc_cyc = cyc;
        saw_miss = 1'b0;
        saw_flash = 1'b0;
        if (a < 32'd256) begin
            kind = 0;
            exp_sel = 5'b00001;
            exp_laddr = a;
            exp_data = main_mem[a[7:0]];
        end else begin
            base = a & ~32'd3;
            slot = -1;
            for (int s = 0; s < 4; s++)
                if (slot_valid[s] && slot_base[s] == base) slot = s;
            if (slot >= 0) begin
                kind = 1;
            end else begin
                kind = 2;
                for (int s = 3; s >= 0; s--)
                    if (!slot_valid[s]) slot = s;
                if (slot < 0) slot = lru[$];
                slot_valid[slot] = 1'b1;
                slot_base[slot] = base;
                filling = 1'b1;
                widx = 0;
                cur_base = base;
            end
            touch(slot);
            exp_sel = 5'(1 << (slot + 1));
            exp_laddr = a & 32'd3;
            exp_data = flash_word(a);
        end
    endfunction

    always @(negedge clk) begin
        if (grst) begin
            if (ram_we) begin
                chk("we_in_fill", {63'd0, txn_open && kind == 2 && filling}, 64'd1);
                chk("we_sel", ram_sel, exp_sel);
                chk("we_addr", ram_addr, widx);
                chk("we_data", ram_wdata, flash_word(cur_base + widx));
                last_fill_sel = ram_sel;
                widx++;
                if (widx == 4) begin
                    filling = 1'b0;
                    last_word_cyc = cyc;
                end
            end else if (ram_sel != 5'd0) begin
                chk("rd_open", txn_open, 1);
                chk("rd_sel", ram_sel, exp_sel);
                chk("rd_addr", ram_addr, exp_laddr);
                last_read_sel = ram_sel;
                last_read_addr = ram_addr;
            end
            if (rvalid) begin
                chk("rv_open", txn_open, 1);
                chk("rdata", rdata, exp_data);
                if (kind != 2) chk("hit_latency", cyc - acc_cyc, 2);
                else chk("fill_resp_latency", {63'd0, (cyc - last_word_cyc) <= 3 && !filling}, 64'd1);
                last_rdata = rdata;
                rv_count++;
                rv_cyc_q.push_back(cyc);
                txn_open = 1'b0;
            end
            chk("busy", busy, txn_open);
            chk("rmiss", rmiss, filling);
            chk("flash_req", flash_req, filling);
            if (filling) chk("flash_addr", flash_addr, cur_base);
            if (rmiss) saw_miss = 1'b1;
            if (flash_req) saw_flash = 1'b1;
        end
    end

    task automatic do_read(input logic [31:0] a, input bit keep);
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            chk("accept_timeout", busy, 0);
            return;
        end
        re = 1'b1;
        raddr = a;
        @(posedge clk);
        #1;
        model_accept(a);
        if (!keep) re = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (txn_open && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("done_timeout", txn_open, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        re = 1'b0;
        model_reset();
        grst = 1'b0;
        repeat (3) @(negedge clk);
        grst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) main_mem[i] = 32'hC000_0000 + i;
        main_mem[255] = 32'hA5A5_A5A5;
        model_reset();
        rv_count = 0;

        // reset held with a pending request
        re = 1'b1;
        raddr = 32'hFF;
        repeat (3) @(negedge clk);
        chk("reset_outs", {63'd0, |{busy, rmiss, rvalid, rdata, flash_req, flash_addr,
                                    ram_we, ram_addr, ram_wdata}}, 64'd0);
        chk("reset_sel", ram_sel, 0);
        re = 1'b0;
        grst = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_no_flash", flash_req, 0);

        // main hit and first address past main
        do_read(32'hFF, 0);
        wait_done();
        chk("main_rdata", last_rdata, 32'hA5A5_A5A5);
        chk("main_sel", last_read_sel, 5'b00001);
        chk("main_addr", last_read_addr, 32'hFF);
        chk("main_no_miss", saw_miss, 0);
        do_read(32'h100, 0);
        wait_done();
        chk("main_edge_miss", saw_miss, 1);

        // cold miss into sub0, then hit
        do_reset();
        do_read(32'h1006, 0);
        wait_done();
        chk("cold_rdata", last_rdata, 32'h33);
        chk("cold_fill_sel", last_fill_sel, 5'b00010);
        chk("cold_words", widx, 4);
        chk("cold_miss", saw_miss, 1);
        do_read(32'h1005, 0);
        wait_done();
        chk("rehit_no_flash", saw_flash, 0);
        chk("rehit_rdata", last_rdata, 32'h22);

        // LRU eviction
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            do_read(32'h1000 * i, 0);
            wait_done();
        end
        do_read(32'h1000, 0);
        wait_done();
        chk("lru_hit_no_flash", saw_flash, 0);
        do_read(32'h5000, 0);
        wait_done();
        chk("evict_sel", last_fill_sel, 5'b00100);
        do_read(32'h2000, 0);
        wait_done();
        chk("evicted_misses", saw_miss, 1);
        do_read(32'h1000, 0);
        wait_done();
        chk("kept_hits", saw_miss, 0);

        // back-to-back with re held high
        rv_count = 0;
        rv_cyc_q.delete();
        do_read(32'h0, 1);
        do_read(32'h1, 1);
        do_read(32'h2, 0);
        wait_done();
        chk("b2b_count", rv_count, 3);
        chk("b2b_gap1", rv_cyc_q[1] - rv_cyc_q[0], 3);
        chk("b2b_gap2", rv_cyc_q[2] - rv_cyc_q[1], 3);
        chk("b2b_last", last_rdata, 32'hC000_0002);

        // reset after two of four words
        words_sampled = 0;
        do_read(32'h3002, 0);
        for (int n = 0; n < 50 && words_sampled < 2; n++) begin
            @(posedge clk);
            #2;
        end
        chk("midfill_words", words_sampled, 2);
        model_reset();
        grst = 1'b0;
        #1;
        chk("midfill_req_drop", flash_req, 0);
        chk("midfill_rmiss_drop", rmiss, 0);
        repeat (2) @(negedge clk);
        grst = 1'b1;
        do_read(32'h3002, 0);
        wait_done();
        chk("refill_miss", saw_miss, 1);
        chk("refill_rdata", last_rdata, 32'h5A00_3002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
